// File: rtl/circle_draw_pkg.sv
// Shared widths, FSM state encoding and octant index type for the midpoint circle rasteriser.
package circle_draw_pkg;

  localparam int unsigned X_W = 9;
  localparam int unsigned Y_W = 8;
  localparam int unsigned R_W = 9;
  localparam int unsigned D_W = 12;

  typedef enum logic [1:0] {
    StLoad = 2'd0,
    StPlot = 2'd1,
    StStep = 2'd2,
    StDone = 2'd3
  } state_e;

  typedef logic [2:0] oct_t;

endpackage

// File: rtl/circle_draw_1_octant_mux.sv
// Maps the current (x,y) step offset and octant index k onto one of the eight symmetric pixels.
module circle_octant_mux
  import circle_draw_pkg::*;
(
  input  logic [X_W-1:0] xl,
  input  logic [Y_W-1:0] yl,
  input  logic [R_W-1:0] x,
  input  logic [R_W-1:0] y,
  input  oct_t           k,
  output logic [X_W-1:0] px,
  output logic [Y_W-1:0] py
);

  logic [R_W-1:0] a;
  logic [R_W-1:0] b;

  // k[2] swaps the roles of x and y, k[0] mirrors horizontally, k[1] vertically.
  assign a = k[2] ? y : x;
  assign b = k[2] ? x : y;

  assign px = X_W'(k[0] ? ({xl[X_W-1], xl} - {1'b0, a}) : ({xl[X_W-1], xl} + {1'b0, a}));
  assign py = Y_W'(k[1] ? ({yl[Y_W-1], yl} - b) : ({yl[Y_W-1], yl} + b));

endmodule

// File: rtl/circle_draw_1.sv
// Midpoint circle rasteriser: one perimeter pixel per clock, sticky done; one circle per reset.
// Defining CIRCLE_DRAW_VALID_EN adds a pixel_valid output flagging each newly emitted point.
module circle_draw_1
  import circle_draw_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [X_W-1:0] xc,
  input  logic [Y_W-1:0] yc,
  input  logic [R_W-1:0] r,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic           done
`ifdef CIRCLE_DRAW_VALID_EN
  ,
  output logic           pixel_valid
`endif
);

  state_e                state_q, state_d;
  oct_t                  k_q, k_d;
  logic [X_W-1:0]        xl_q, xl_d;
  logic [Y_W-1:0]        yl_q, yl_d;
  logic [R_W-1:0]        x_q, x_d;
  logic [R_W-1:0]        y_q, y_d;
  logic signed [D_W-1:0] d_q, d_d;
  logic [X_W-1:0]        x_out_q, x_out_d;
  logic [Y_W-1:0]        y_out_q, y_out_d;
  logic                  done_q, done_d;

  logic [X_W-1:0]        px;
  logic [Y_W-1:0]        py;
  logic signed [D_W-1:0] xn, ycur, ydec, ynew;

  circle_octant_mux u_mux (
    .xl (xl_q),
    .yl (yl_q),
    .x  (x_q),
    .y  (y_q),
    .k  (k_q),
    .px (px),
    .py (py)
  );

  assign xn   = $signed({{(D_W-R_W){1'b0}}, x_q}) + 12'sd1;
  assign ycur = $signed({{(D_W-R_W){1'b0}}, y_q});
  assign ydec = ycur - 12'sd1;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    xl_d    = xl_q;
    yl_d    = yl_q;
    x_d     = x_q;
    y_d     = y_q;
    d_d     = d_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    done_d  = done_q;
    ynew    = ycur;
    unique case (state_q)
      StLoad: begin
        xl_d    = xc;
        yl_d    = yc;
        x_d     = '0;
        y_d     = r;
        d_d     = 12'sd1 - $signed({{(D_W-R_W){1'b0}}, r});
        k_d     = '0;
        state_d = StPlot;
      end
      StPlot: begin
        x_out_d = px;
        y_out_d = py;
        k_d     = k_q + 3'd1;
        if (k_q == 3'd7) state_d = StStep;
      end
      StStep: begin
        x_d = R_W'(xn);
        if (d_q[D_W-1]) begin
          d_d = d_q + (xn <<< 1) + 12'sd1;
        end else begin
          ynew = ydec;
          y_d  = R_W'(ydec);
          d_d  = d_q + ((xn - ydec) <<< 1) + 12'sd1;
        end
        if (xn <= ynew) begin
          state_d = StPlot;
        end else begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: ;
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StLoad;
      k_q     <= '0;
      xl_q    <= '0;
      yl_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      d_q     <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      xl_q    <= xl_d;
      yl_q    <= yl_d;
      x_q     <= x_d;
      y_q     <= y_d;
      d_q     <= d_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      done_q  <= done_d;
    end
  end

  assign x_out = x_out_q;
  assign y_out = y_out_q;
  assign done  = done_q;

`ifdef CIRCLE_DRAW_VALID_EN
  logic pixel_valid_q;

  // The PLOT edge registers the point, so valid lags the PLOT state by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pixel_valid_q <= 1'b0;
    else        pixel_valid_q <= (state_q == StPlot);
  end

  assign pixel_valid = pixel_valid_q;
`endif

endmodule

// File: tb/tb_circle_draw_1.sv
// Directed scoreboard bench for circle_draw_1; define CIRCLE_DRAW_VALID_EN to also check pixel_valid.
module tb_circle_draw_1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] xc = '0;
  logic [7:0] yc = '0;
  logic [8:0] r = '0;
  logic [8:0] x_out;
  logic [7:0] y_out;
  logic       done;
`ifdef CIRCLE_DRAW_VALID_EN
  logic       pixel_valid;
  int         n_valid;
`endif

  typedef struct {int x; int y;} pt_t;

  pt_t exp_q[$];
  int  em_x[$];
  int  em_y[$];
  int  n_tests = 0;
  int  n_fail = 0;
  int  edges;

  circle_draw_1 dut (
    .clk   (clk),
    .reset (reset),
    .xc    (xc),
    .yc    (yc),
    .r     (r),
    .x_out (x_out),
    .y_out (y_out),
    .done  (done)
`ifdef CIRCLE_DRAW_VALID_EN
    ,
    .pixel_valid (pixel_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sx(input logic [8:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sy(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  // Reference midpoint algorithm in plain integers, wrapped to output widths.
  task automatic model(input int cx, input int cy, input int rr);
    int x, y, d, a, b;
    logic signed [8:0] tx;
    logic signed [7:0] ty;
    pt_t p;
    x = 0; y = rr; d = 1 - rr;
    do begin
      for (int k = 0; k < 8; k++) begin
        a  = (k < 4) ? x : y;
        b  = (k < 4) ? y : x;
        tx = 9'(cx + (((k % 2) == 1) ? -a : a));
        ty = 8'(cy + ((((k / 2) % 2) == 1) ? -b : b));
        p.x = int'(tx);
        p.y = int'(ty);
        exp_q.push_back(p);
      end
      x++;
      if (d < 0) d += 2 * x + 1;
      else begin
        y--;
        d += 2 * (x - y) + 1;
      end
    end while (x <= y);
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input int cx, input int cy, input int rr, input bit scramble);
    pt_t e;
    model(cx, cy, rr);
    em_x.delete();
    em_y.delete();
`ifdef CIRCLE_DRAW_VALID_EN
    n_valid = 0;
`endif
    @(negedge clk);
    xc = 9'(cx); yc = 8'(cy); r = 9'(rr);
    reset = 1'b1;
    @(posedge clk); #1;
    edges = 1;
    chk("load_done", int'(done), 0);
    if (scramble) begin
      xc = xc ^ 9'h0aa;
      yc = yc + 8'd5;
      r  = 9'd3;
    end
    while (exp_q.size() > 0) begin
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        edges++;
        e = exp_q.pop_front();
        chk("plot_x", sx(x_out), e.x);
        chk("plot_y", sy(y_out), e.y);
        em_x.push_back(sx(x_out));
        em_y.push_back(sy(y_out));
`ifdef CIRCLE_DRAW_VALID_EN
        chk("plot_valid", int'(pixel_valid), 1);
        n_valid += int'(pixel_valid);
`endif
      end
      @(posedge clk); #1;
      edges++;
      chk("step_hold_x", sx(x_out), e.x);
      chk("step_hold_y", sy(y_out), e.y);
      chk("step_done", int'(done), int'(exp_q.size() == 0));
`ifdef CIRCLE_DRAW_VALID_EN
      chk("step_valid", int'(pixel_valid), 0);
      n_valid += int'(pixel_valid);
`endif
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_sticky", int'(done), 1);
    chk("done_hold_x", sx(x_out), e.x);
    chk("done_hold_y", sy(y_out), e.y);
  endtask

  initial begin
    int r8x[6] = '{0, 1, 2, 3, 4, 5};
    int r8y[6] = '{8, 8, 8, 7, 7, 6};
    int r3x[8] = '{100, 100, 100, 100, 103, 97, 103, 97};
    int r3y[8] = '{53, 53, 47, 47, 50, 50, 50, 50};

    repeat (2) @(negedge clk);
    chk("rst_x", sx(x_out), 0);
    chk("rst_y", sy(y_out), 0);
    chk("rst_done", int'(done), 0);

    // r=8 at origin: six steps, 48 points, done on the 55th edge after release.
    run(0, 0, 8, 1'b0);
    chk("r8_points", em_x.size(), 48);
    chk("r8_edges", edges, 55);
    for (int s = 0; s < 6; s++) begin
      if (em_x.size() > 8 * s) begin
        chk("r8_step_x", em_x[8 * s], r8x[s]);
        chk("r8_step_y", em_y[8 * s], r8y[s]);
      end
    end
`ifdef CIRCLE_DRAW_VALID_EN
    chk("r8_valid_count", n_valid, 48);
`endif

    hold_reset();
    run(5, -3, 0, 1'b0);
    chk("r0_edges", edges, 10);
    for (int i = 0; i < 8; i++) begin
      chk("r0_x", em_x[i], 5);
      chk("r0_y", em_y[i], -3);
    end

    hold_reset();
    run(100, 50, 3, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("r3_x", em_x[i], r3x[i]);
      chk("r3_y", em_y[i], r3y[i]);
    end

    hold_reset();
    run(250, 0, 20, 1'b0);
    chk("wrap_k0_x", em_x[0], 250);
    chk("wrap_k4_x", em_x[4], -242);

    // Inputs disturbed right after LOAD must not affect the circle.
    hold_reset();
    run(0, 0, 8, 1'b1);
    chk("scr_points", em_x.size(), 48);
    chk("scr_edges", edges, 55);
`ifdef CIRCLE_DRAW_VALID_EN
    chk("scr_valid_count", n_valid, 48);
`endif

    // Asynchronous abort mid-draw, then a clean restart.
    hold_reset();
    @(negedge clk);
    xc = 9'd10; yc = 8'd10; r = 9'd8;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #3;
    chk("pre_abort_nonzero", int'(x_out != 9'd0), 1);
    reset = 1'b0;
    #1;
    chk("abort_x", sx(x_out), 0);
    chk("abort_y", sy(y_out), 0);
    chk("abort_done", int'(done), 0);
    repeat (2) @(negedge clk);
    run(-20, 30, 5, 1'b0);
    chk("restart_first_x", em_x[0], -20);
    chk("restart_first_y", em_y[0], 35);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
